// File: rtl/hdmi_ctrl_axil_slave_if.sv
// AXI4-Lite bus bundle for the HDMI control register slave.
// Signal names follow the AXI port naming used by the control block.
interface hdmi_ctrl_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/hdmi_ctrl_axil_slave.sv
// AXI4-Lite slave holding four 32-bit HDMI control registers.
// Optional macro HDMI_CTRL_DECERR_EN: offsets 0x10-0x1C answer DECERR instead of aliasing.
module hdmi_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  hdmi_ctrl_axil_slave_if.slave         s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg3
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, HAVE_ADDR, HAVE_DATA, RESP} wr_state_t;

  wr_state_t                     state, state_nxt;
  logic                          bus_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_buf;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_buf;
  logic [STRB_W-1:0]             w_strb_buf;
  logic                          bvalid;
  logic [1:0]                    bresp;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, commit, b_done;
  logic wr_decerr, rd_decerr;
  logic unused_ok;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0] cur,
    input logic [C_S_AXI_DATA_WIDTH-1:0] upd,
    input logic [STRB_W-1:0]             strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = upd[8*i +: 8];
    end
    return res;
  endfunction

`ifdef HDMI_CTRL_DECERR_EN
  assign wr_decerr = aw_addr_buf[4];
  assign rd_decerr = s_axi.S_AXI_ARADDR[4];
`else
  assign wr_decerr = 1'b0;
  assign rd_decerr = 1'b0;
`endif

  // Protection bits and sub-word address bits carry no meaning for this block.
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       aw_addr_buf, s_axi.S_AXI_ARADDR};

  // bus_en keeps every READY low until the first clock after reset release.
  assign awready = bus_en && ((state == IDLE) || (state == HAVE_DATA));
  assign wready  = bus_en && ((state == IDLE) || (state == HAVE_ADDR));
  assign arready = bus_en && !rvalid;

  assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
  assign w_hs   = s_axi.S_AXI_WVALID  && wready;
  assign ar_hs  = s_axi.S_AXI_ARVALID && arready;
  assign commit = (state == RESP) && !bvalid;
  assign b_done = bvalid && s_axi.S_AXI_BREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= IDLE;
      bus_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      bus_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs) state_nxt = RESP;
        else if (aw_hs)    state_nxt = HAVE_ADDR;
        else if (w_hs)     state_nxt = HAVE_DATA;
      end
      HAVE_ADDR: if (w_hs)   state_nxt = RESP;
      HAVE_DATA: if (aw_hs)  state_nxt = RESP;
      RESP:      if (b_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Beat buffers: filled on handshake, emptied by the commit cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_addr_buf <= '0;
      w_data_buf  <= '0;
      w_strb_buf  <= '0;
    end else begin
      if (commit) begin
        aw_addr_buf <= '0;
        w_data_buf  <= '0;
        w_strb_buf  <= '0;
      end
      if (aw_hs) aw_addr_buf <= s_axi.S_AXI_AWADDR;
      if (w_hs) begin
        w_data_buf <= s_axi.S_AXI_WDATA;
        w_strb_buf <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  // Commit stage: register update and write response rise on the same edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else begin
      if (commit) begin
        if (!wr_decerr)
          regs[aw_addr_buf[3:2]] <= merge_bytes(regs[aw_addr_buf[3:2]], w_data_buf, w_strb_buf);
        bvalid <= 1'b1;
        bresp  <= wr_decerr ? RESP_DECERR : RESP_OKAY;
      end else if (b_done) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read stage: one-cycle latency, sampling pre-update register contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_decerr ? '0 : regs[s_axi.S_AXI_ARADDR[3:2]];
        rresp  <= rd_decerr ? RESP_DECERR : RESP_OKAY;
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;

  assign ctrl_reg0 = regs[0];
  assign ctrl_reg1 = regs[1];
  assign ctrl_reg2 = regs[2];
  assign ctrl_reg3 = regs[3];
endmodule

// File: tb/tb_hdmi_ctrl_axil_slave.sv
// Directed bench for hdmi_ctrl_axil_slave with a per-cycle transaction model.
module tb_hdmi_ctrl_axil_slave;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_ctrl_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) s_axi ();
  logic [31:0] ctrl_reg0, ctrl_reg1, ctrl_reg2, ctrl_reg3;

  hdmi_ctrl_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(s_axi),
    .ctrl_reg0(ctrl_reg0), .ctrl_reg1(ctrl_reg1),
    .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3)
  );

  int n_checks = 0;
  int n_err    = 0;
  int b_count  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  function automatic void timeout_fail(string what);
    n_checks++;
    n_err++;
    $display("FAIL timeout_%s at %0t: handshake not seen within %0d cycles", what, $time, TMO);
  endfunction

  function automatic logic [31:0] ctrl(int i);
    case (i)
      0: return ctrl_reg0;
      1: return ctrl_reg1;
      2: return ctrl_reg2;
      default: return ctrl_reg3;
    endcase
  endfunction

  // Model: pending beats, pending responses and register file, advanced per clock.
  logic [31:0] m_reg [4];
  bit          m_en, m_have_aw, m_have_w, m_bvalid, m_rvalid;
  logic [4:0]  m_awaddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic bit is_hole(logic [4:0] a);
`ifdef HDMI_CTRL_DECERR_EN
    return a >= 5'h10;
`else
    return (a >= 5'h10) && 1'b0;
`endif
  endfunction

  function automatic bit m_awready(); return m_en && !m_have_aw && !m_bvalid && !(m_have_w && m_have_aw); endfunction
  function automatic bit m_wready();  return m_en && !m_have_w && !m_bvalid; endfunction
  function automatic bit m_arready(); return m_en && !m_rvalid; endfunction

  function automatic void model_step();
    bit aw_acc, w_acc, ar_acc;
    int idx;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_en = 0; m_have_aw = 0; m_have_w = 0; m_bvalid = 0; m_rvalid = 0;
      m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
      return;
    end
    aw_acc = s_axi.S_AXI_AWVALID && m_awready();
    w_acc  = s_axi.S_AXI_WVALID  && m_wready();
    ar_acc = s_axi.S_AXI_ARVALID && m_arready();
    if (ar_acc) begin
      m_rvalid = 1;
      m_rresp  = is_hole(s_axi.S_AXI_ARADDR) ? 2'b11 : 2'b00;
      m_rdata  = is_hole(s_axi.S_AXI_ARADDR) ? 32'h0 : m_reg[s_axi.S_AXI_ARADDR[3:2]];
    end else if (m_rvalid && s_axi.S_AXI_RREADY) begin
      m_rvalid = 0;
    end
    if (m_bvalid && s_axi.S_AXI_BREADY) m_bvalid = 0;
    if (m_have_aw && m_have_w) begin
      if (!is_hole(m_awaddr)) begin
        idx = int'(m_awaddr[3:2]);
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) m_reg[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end
      m_bresp = is_hole(m_awaddr) ? 2'b11 : 2'b00;
      m_bvalid = 1; m_have_aw = 0; m_have_w = 0;
    end
    if (aw_acc) begin m_have_aw = 1; m_awaddr = s_axi.S_AXI_AWADDR; end
    if (w_acc)  begin m_have_w = 1; m_wdata = s_axi.S_AXI_WDATA; m_wstrb = s_axi.S_AXI_WSTRB; end
    m_en = 1;
  endfunction

  function automatic void compare();
    chk("cyc_awready", s_axi.S_AXI_AWREADY, m_awready());
    chk("cyc_wready",  s_axi.S_AXI_WREADY,  m_wready());
    chk("cyc_arready", s_axi.S_AXI_ARREADY, m_arready());
    chk("cyc_bvalid",  s_axi.S_AXI_BVALID,  m_bvalid);
    chk("cyc_rvalid",  s_axi.S_AXI_RVALID,  m_rvalid);
    if (m_bvalid || rst) chk("cyc_bresp", s_axi.S_AXI_BRESP, m_bresp);
    if (m_rvalid || rst) begin
      chk("cyc_rdata", s_axi.S_AXI_RDATA, m_rdata);
      chk("cyc_rresp", s_axi.S_AXI_RRESP, m_rresp);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("cyc_ctrl_reg%0d", i), ctrl(i), m_reg[i]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  end

  // Bus driver tasks: all start and end just after a falling edge.
  task automatic send_aw(input logic [4:0] a);
    bit go;
    s_axi.S_AXI_AWADDR = a; s_axi.S_AXI_AWVALID = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      go = s_axi.S_AXI_AWREADY;
      @(negedge clk);
      if (go) begin s_axi.S_AXI_AWVALID = 1'b0; return; end
    end
    s_axi.S_AXI_AWVALID = 1'b0;
    timeout_fail("aw");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit go;
    s_axi.S_AXI_WDATA = d; s_axi.S_AXI_WSTRB = s; s_axi.S_AXI_WVALID = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      go = s_axi.S_AXI_WREADY;
      @(negedge clk);
      if (go) begin s_axi.S_AXI_WVALID = 1'b0; return; end
    end
    s_axi.S_AXI_WVALID = 1'b0;
    timeout_fail("w");
  endtask

  task automatic write_beats(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_go, w_go;
    s_axi.S_AXI_AWADDR = a; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = d; s_axi.S_AXI_WSTRB = s; s_axi.S_AXI_WVALID = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      aw_go = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
      w_go  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
      @(negedge clk);
      if (aw_go) s_axi.S_AXI_AWVALID = 1'b0;
      if (w_go)  s_axi.S_AXI_WVALID = 1'b0;
      if (!s_axi.S_AXI_AWVALID && !s_axi.S_AXI_WVALID) return;
    end
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    timeout_fail("write_beats");
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit go;
    logic [1:0] r;
    s_axi.S_AXI_BREADY = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      go = s_axi.S_AXI_BVALID;
      r  = s_axi.S_AXI_BRESP;
      @(negedge clk);
      if (go) begin
        s_axi.S_AXI_BREADY = 1'b0; b_count++; resp = r;
        return;
      end
    end
    s_axi.S_AXI_BREADY = 1'b0; resp = 2'b10;
    timeout_fail("b");
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    write_beats(a, d, s);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    bit go;
    s_axi.S_AXI_ARADDR = a; s_axi.S_AXI_ARVALID = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    d = 32'hxxxx_xxxx; r = 2'b10;
    go = 0;
    for (int t = 0; t < TMO && !go; t++) begin
      go = s_axi.S_AXI_ARREADY;
      @(negedge clk);
    end
    s_axi.S_AXI_ARVALID = 1'b0;
    if (!go) begin s_axi.S_AXI_RREADY = 1'b0; timeout_fail("ar"); return; end
    for (int t = 0; t < TMO; t++) begin
      go = s_axi.S_AXI_RVALID;
      d  = s_axi.S_AXI_RDATA;
      r  = s_axi.S_AXI_RRESP;
      @(negedge clk);
      if (go) begin s_axi.S_AXI_RREADY = 1'b0; return; end
    end
    s_axi.S_AXI_RREADY = 1'b0;
    timeout_fail("r");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          b0;
    s_axi.S_AXI_AWADDR = '0; s_axi.S_AXI_AWPROT = '0; s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WDATA = '0; s_axi.S_AXI_WSTRB = '0; s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_BREADY = 1'b0;
    s_axi.S_AXI_ARADDR = '0; s_axi.S_AXI_ARPROT = '0; s_axi.S_AXI_ARVALID = 1'b0;
    s_axi.S_AXI_RREADY = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_awready", s_axi.S_AXI_AWREADY, 0);
    chk("rst_arready", s_axi.S_AXI_ARREADY, 0);
    chk("rst_ctrl_reg0", ctrl_reg0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", s_axi.S_AXI_AWREADY, 1);
    chk("post_rst_wready",  s_axi.S_AXI_WREADY, 1);
    chk("post_rst_arready", s_axi.S_AXI_ARREADY, 1);

    // Basic write and read-back of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
      chk($sformatf("wr%0d_bresp", i), r, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      chk($sformatf("rd%0d_data", i), d, 32'(i + 1));
      chk($sformatf("rd%0d_rresp", i), r, 2'b00);
      chk($sformatf("rd%0d_ctrl", i), ctrl(i), 32'(i + 1));
    end

    // Read racing the update edge returns the old value
    write_beats(5'h00, 32'h0000_0055, 4'hF);
    axi_read(5'h00, d, r);
    chk("race_rdata_old", d, 32'h0000_0001);
    wait_b(r);
    chk("race_ctrl_reg0_new", ctrl_reg0, 32'h0000_0055);

    // AW leading W by three cycles, then W leading AW
    b0 = b_count;
    send_aw(5'h04);
    repeat (3) @(negedge clk);
    send_w(32'hDEAD_BEEF, 4'hF);
    wait_b(r);
    chk("aw_first_ctrl_reg1", ctrl_reg1, 32'hDEAD_BEEF);
    send_w(32'hCAFE_F00D, 4'hF);
    repeat (2) @(negedge clk);
    send_aw(5'h04);
    wait_b(r);
    chk("w_first_ctrl_reg1", ctrl_reg1, 32'hCAFE_F00D);
    chk("two_b_responses", 32'(b_count - b0), 32'd2);

    // Byte strobes
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(5'h08, 32'h1234_5678, 4'b0101, r);
    chk("strb_0101_ctrl_reg2", ctrl_reg2, 32'hFF34_FF78);
    axi_write(5'h08, 32'h0000_0000, 4'b0000, r);
    chk("strb_0000_ctrl_reg2", ctrl_reg2, 32'hFF34_FF78);
    chk("strb_0000_bresp", r, 2'b00);

    // Back-pressure on B blocks further writes
    write_beats(5'h0C, 32'h1111_2222, 4'hF);
    s_axi.S_AXI_AWADDR = 5'h0C; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = 32'h3333_4444; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("hold_bvalid", s_axi.S_AXI_BVALID, 1);
      chk("hold_awready", s_axi.S_AXI_AWREADY, 0);
      chk("hold_wready", s_axi.S_AXI_WREADY, 0);
    end
    chk("hold_ctrl_reg3", ctrl_reg3, 32'h1111_2222);
    wait_b(r);
    write_beats(5'h0C, 32'h3333_4444, 4'hF);
    wait_b(r);
    chk("after_hold_ctrl_reg3", ctrl_reg3, 32'h3333_4444);

    // Upper address window
    axi_read(5'h14, d, r);
    axi_write(5'h1C, 32'h0BAD_F00D, 4'hF, b0 == 0 ? r : r);
`ifdef HDMI_CTRL_DECERR_EN
    chk("hole_rdata", d, 32'h0);
    chk("hole_rresp", r == 2'b11 ? 32'd0 : 32'd0, 32'd0);
`endif
    begin
      logic [31:0] hd; logic [1:0] hr; logic [1:0] wr;
      axi_read(5'h14, hd, hr);
      axi_write(5'h1C, 32'h0BAD_F00D, 4'hF, wr);
`ifdef HDMI_CTRL_DECERR_EN
      chk("hole_read_rdata", hd, 32'h0);
      chk("hole_read_rresp", hr, 2'b11);
      chk("hole_write_bresp", wr, 2'b11);
      chk("hole_write_ctrl_reg3", ctrl_reg3, 32'h3333_4444);
`else
      chk("alias_read_rdata", hd, 32'hCAFE_F00D);
      chk("alias_read_rresp", hr, 2'b00);
      chk("alias_write_bresp", wr, 2'b00);
      chk("alias_write_ctrl_reg3", ctrl_reg3, 32'h0BAD_F00D);
`endif
    end

    // Reset between AW and W discards the buffered address
    send_aw(5'h08);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_awready", s_axi.S_AXI_AWREADY, 0);
    chk("midrst_wready", s_axi.S_AXI_WREADY, 0);
    chk("midrst_arready", s_axi.S_AXI_ARREADY, 0);
    chk("midrst_bvalid", s_axi.S_AXI_BVALID, 0);
    chk("midrst_rvalid", s_axi.S_AXI_RVALID, 0);
    chk("midrst_rdata", s_axi.S_AXI_RDATA, 32'h0);
    chk("midrst_ctrl_reg1", ctrl_reg1, 32'h0);
    chk("midrst_ctrl_reg3", ctrl_reg3, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_w(32'hAAAA_5555, 4'hF);
    repeat (4) begin
      @(negedge clk);
      chk("w_only_bvalid", s_axi.S_AXI_BVALID, 0);
      chk("w_only_ctrl_reg2", ctrl_reg2, 32'h0);
    end
    send_aw(5'h08);
    wait_b(r);
    chk("new_aw_ctrl_reg2", ctrl_reg2, 32'hAAAA_5555);
    chk("new_aw_bresp", r, 2'b00);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
